spigpio_master: RTL and testbench

- SPI initiator that drives the 16-bit GPIO-expander slave.
- Each host request becomes one frame: bit15 = rw (0 write, 1 read), bits14:8 = addr, bits7:0 = data, sent MSB first.
- Reads take two frames. The first is the command frame. The second is a dummy frame to address 0x7F (unmapped, no side effect), during which the slave's loaded data is clocked back on miso.
- Sits between a local controller/CPU register bank and the off-chip or on-chip expander.

---
 rtl/spigpio_master.sv | 164 ++++++++++++++++
 tb/tb_spigpio_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spigpio_master.sv
// SPI initiator for the 16-bit GPIO-expander slave.
// Each request is one or two 16-bit frames sent MSB first:
//   frame = {rw, addr[6:0], data[7:0]}
// A read sends the command frame, then a dummy frame to address 0x7F.
// The slave returns the requested byte on miso during the dummy frame.
//
// Handshake: start is sampled only while busy=0. rw/addr/wdata are captured
// in the same cycle. done pulses high for one cycle with busy=0. rdata holds
// the last read result from that done until the next read's done.
//
// Timing, with D = CLK_DIV and C = CS_IDLE, counted from the start cycle t0:
//   - cs falls at t0+1;
//   - rising edge k at t0+1+D*(2k-1), falling edge k at t0+1+2Dk;
//   - cs rises at t0+1+33D, followed by C cycles of cs-high gap.
module spigpio_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_IDLE - 1);
  // Dummy read to an unmapped address; it has no side effect in the slave.
  localparam logic [15:0] DUMMY_FRAME = {1'b1, 7'h7F, 8'h00};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT_H = 3'd1,
    SHIFT_L = 3'd2,
    HOLD    = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [15:0]      frame;     // current frame, shifted left at each falling edge
  logic             phase;     // 0 = command frame, 1 = dummy frame of a read
  logic             is_read;
  logic [4:0]       bit_cnt;   // falling edges completed in this frame, 0..16
  logic [CNT_W-1:0] div_cnt;   // cycles spent in the current sclk phase / gap
  logic [7:0]       cap;       // miso samples of falling edges 9..16

  logic div_end;
  logic gap_end;
  logic last_bit;
  logic chain_dummy;

  assign div_end     = (div_cnt == DIV_LAST);
  assign gap_end     = (div_cnt == GAP_LAST);
  assign last_bit    = (bit_cnt == 5'd15);
  assign chain_dummy = is_read && !phase;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)   next_state = SHIFT_L;
      SHIFT_L: if (div_end) next_state = SHIFT_H;
      SHIFT_H: if (div_end) next_state = last_bit ? HOLD : SHIFT_L;
      HOLD:    if (div_end) next_state = GAP;
      GAP:     if (gap_end) next_state = chain_dummy ? SHIFT_L : DONE;
      DONE:                 next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state != IDLE) && (state != DONE);
    done = (state == DONE);
  end

  // Frame, counters, capture register and registered SPI pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame   <= '0;
      phase   <= 1'b0;
      is_read <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
      cap     <= '0;
      rdata   <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      // The divider restarts whenever the state changes, i.e. at every sclk toggle.
      if (state == IDLE || next_state != state) div_cnt <= '0;
      else                                      div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            frame   <= rw ? {1'b1, addr, 8'h00} : {1'b0, addr, wdata};
            is_read <= rw;
            phase   <= 1'b0;
            bit_cnt <= '0;
            cs      <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= rw;
          end
        end
        SHIFT_L: begin
          // First cycle after falling edge k; the slave's byte arrives on k = 9..16.
          if (div_cnt == '0 && bit_cnt >= 5'd9) cap <= {cap[6:0], miso};
          if (div_end) sclk <= 1'b1;
        end
        SHIFT_H: begin
          if (div_end) begin
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 5'd1;
            frame   <= {frame[14:0], 1'b0};
            if (!last_bit) mosi <= frame[14];
          end
        end
        HOLD: begin
          // Falling edge 16 lands here rather than in SHIFT_L.
          if (div_cnt == '0 && bit_cnt >= 5'd9) cap <= {cap[6:0], miso};
          if (div_end) begin
            cs   <= 1'b1;
            mosi <= 1'b0;
          end
        end
        GAP: begin
          if (gap_end) begin
            if (chain_dummy) begin
              frame   <= DUMMY_FRAME;
              phase   <= 1'b1;
              bit_cnt <= '0;
              cs      <= 1'b0;
              mosi    <= DUMMY_FRAME[15];
            end else if (is_read) begin
              rdata <= cap;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spigpio_master.sv
// Bench for spigpio_master.
// Instance 0 uses the default divider and gap (4/4); instance 1 uses 1/1.
// Each instance talks to a small behavioural model of the GPIO-expander slave:
//   - registers 0x00..0x09 drive the individual outputs;
//   - register 0x0A drives all outputs at once;
//   - 0x0E/0x0F return the input pins;
//   - 0x10..0x1F are RAM.
module tb_spigpio_master;

  logic       clk = 1'b0;
  logic       rstn_v  [2];
  logic       start_v [2];
  logic       rw_v    [2];
  logic [6:0] addr_v  [2];
  logic [7:0] wdata_v [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic [7:0] rdata_v [2];
  logic       sclk_v  [2];
  logic       cs_v    [2];
  logic       mosi_v  [2];
  logic       miso_v  [2];
  logic [9:0] gpioin = 10'h000;

  int total = 0;
  int bad   = 0;

  // Results of the most recent txn0 call.
  int       r_done_at;
  int       r_rises;
  int       r_cs_low;
  int       r_cs_falls;
  int       r_dones;
  logic [7:0] r_rdata;

  always #5 clk = ~clk;

  spigpio_master #(.CLK_DIV(4), .CS_IDLE(4)) u_dut (
    .clk(clk), .rst_n(rstn_v[0]), .start(start_v[0]), .rw(rw_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata_v[0]),
    .sclk(sclk_v[0]), .cs(cs_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0])
  );

  spigpio_master #(.CLK_DIV(1), .CS_IDLE(1)) u_fast (
    .clk(clk), .rst_n(rstn_v[1]), .start(start_v[1]), .rw(rw_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata_v[1]),
    .sclk(sclk_v[1]), .cs(cs_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1])
  );

  // Slave models.
  // A frame is executed on cs rising, and only if all 16 bits arrived.
  // miso is registered: data[7] appears after rising edge 9.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic        sclk_q     = 1'b0;
    logic        cs_q       = 1'b1;
    logic        miso_r     = 1'b0;
    logic [15:0] sr_in      = '0;
    logic [15:0] sr_out     = '0;
    logic [4:0]  rises      = '0;
    logic [9:0]  gpioout    = '0;
    logic [7:0]  ram [16];
    logic [15:0] last_frame = '0;
    logic [15:0] prev_frame = '0;
    int          frames     = 0;

    assign miso_v[g] = miso_r;

    always @(posedge clk) begin
      sclk_q <= sclk_v[g];
      cs_q   <= cs_v[g];
      if (!cs_v[g] && cs_q) begin
        rises <= '0;
      end else if (!cs_v[g] && sclk_v[g] && !sclk_q) begin
        sr_in  <= {sr_in[14:0], mosi_v[g]};
        miso_r <= sr_out[15];
        sr_out <= {sr_out[14:0], 1'b0};
        rises  <= rises + 5'd1;
      end
      if (cs_v[g] && !cs_q && rises == 5'd16) begin
        frames     <= frames + 1;
        prev_frame <= last_frame;
        last_frame <= sr_in;
        if (!sr_in[15]) begin
          if (sr_in[14:8] <= 7'd9)          gpioout[sr_in[11:8]] <= sr_in[0];
          else if (sr_in[14:8] == 7'h0A)    gpioout <= {10{sr_in[0]}};
          else if (sr_in[14:12] == 3'b001)  ram[sr_in[11:8]] <= sr_in[7:0];
        end else begin
          if (sr_in[14:8] == 7'h0E)         sr_out <= {8'h00, gpioin[7:0]};
          else if (sr_in[14:8] == 7'h0F)    sr_out <= {14'h0000, gpioin[9:8]};
          else if (sr_in[14:12] == 3'b001)  sr_out <= {8'h00, ram[sr_in[11:8]]};
          else                              sr_out <= '0;
        end
      end
    end
  end

  // Driver for instance 0: one transaction from a negedge, measuring it until 3 cycles after done.
  // With reject set, extra start pulses (write 0x05 <- 0x01) are issued while busy.
  task automatic txn0(input logic r, input logic [6:0] a, input logic [7:0] d, input bit reject);
    logic p_sclk;
    logic p_cs;
    start_v[0] = 1'b1; rw_v[0] = r; addr_v[0] = a; wdata_v[0] = d;
    r_done_at = -1; r_rises = 0; r_cs_low = 0; r_cs_falls = 0; r_dones = 0; r_rdata = 8'h00;
    p_sclk = sclk_v[0]; p_cs = cs_v[0];
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (sclk_v[0] && !p_sclk) r_rises++;
      if (!cs_v[0]) r_cs_low++;
      if (!cs_v[0] && p_cs) r_cs_falls++;
      if (done_v[0]) begin
        r_dones++;
        if (r_done_at < 0) begin
          r_done_at = c;
          r_rdata = rdata_v[0];
        end
      end
      p_sclk = sclk_v[0]; p_cs = cs_v[0];
      if (reject && busy_v[0] && (c % 20 == 5)) begin
        start_v[0] = 1'b1; rw_v[0] = 1'b0; addr_v[0] = 7'h05; wdata_v[0] = 8'h01;
      end
      if (r_done_at >= 0 && c >= r_done_at + 3) break;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      rstn_v[i] = 1'b0; start_v[i] = 1'b0; rw_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++; if (cs_v[i] !== 1'b1)     begin bad++; $display("FAIL reset_cs[%0d] got=%b exp=1", i, cs_v[i]); end
      total++; if (sclk_v[i] !== 1'b0)   begin bad++; $display("FAIL reset_sclk[%0d] got=%b exp=0", i, sclk_v[i]); end
      total++; if (mosi_v[i] !== 1'b0)   begin bad++; $display("FAIL reset_mosi[%0d] got=%b exp=0", i, mosi_v[i]); end
      total++; if (busy_v[i] !== 1'b0)   begin bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy_v[i]); end
      total++; if (done_v[i] !== 1'b0)   begin bad++; $display("FAIL reset_done[%0d] got=%b exp=0", i, done_v[i]); end
      total++; if (rdata_v[i] !== 8'h00) begin bad++; $display("FAIL reset_rdata[%0d] got=%h exp=00", i, rdata_v[i]); end
    end
    rstn_v[0] = 1'b1; rstn_v[1] = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy_v[0] !== 1'b0 || cs_v[0] !== 1'b1) begin bad++; $display("FAIL post_reset_idle got busy=%b cs=%b exp busy=0 cs=1", busy_v[0], cs_v[0]); end
  endtask

  task automatic test_write_p3;
    int base;
    base = g_slv[0].frames;
    txn0(1'b0, 7'h03, 8'h01, 1'b0);
    total++; if (r_done_at != 137)  begin bad++; $display("FAIL wr_latency got=%0d exp=137", r_done_at); end
    total++; if (r_rises != 16)     begin bad++; $display("FAIL wr_rises got=%0d exp=16", r_rises); end
    total++; if (r_cs_low != 132)   begin bad++; $display("FAIL wr_cs_low got=%0d exp=132", r_cs_low); end
    total++; if (r_dones != 1)      begin bad++; $display("FAIL wr_dones got=%0d exp=1", r_dones); end
    total++; if (g_slv[0].frames != base + 1) begin bad++; $display("FAIL wr_frames got=%0d exp=%0d", g_slv[0].frames, base + 1); end
    total++; if (g_slv[0].last_frame !== 16'h0301) begin bad++; $display("FAIL wr_frame got=%h exp=0301", g_slv[0].last_frame); end
    total++; if (g_slv[0].gpioout[3] !== 1'b1) begin bad++; $display("FAIL wr_gpioout3 got=%b exp=1", g_slv[0].gpioout[3]); end
  endtask

  task automatic test_ram_roundtrip;
    int base;
    txn0(1'b0, 7'h13, 8'hA5, 1'b0);
    total++; if (r_done_at != 137) begin bad++; $display("FAIL ram_wr_latency got=%0d exp=137", r_done_at); end
    base = g_slv[0].frames;
    txn0(1'b1, 7'h13, 8'h00, 1'b0);
    total++; if (r_done_at != 273) begin bad++; $display("FAIL ram_rd_latency got=%0d exp=273", r_done_at); end
    total++; if (r_rises != 32)    begin bad++; $display("FAIL ram_rd_rises got=%0d exp=32", r_rises); end
    total++; if (r_cs_low != 264)  begin bad++; $display("FAIL ram_rd_cs_low got=%0d exp=264", r_cs_low); end
    total++; if (r_cs_falls != 2)  begin bad++; $display("FAIL ram_rd_cs_falls got=%0d exp=2", r_cs_falls); end
    total++; if (g_slv[0].frames != base + 2) begin bad++; $display("FAIL ram_rd_frames got=%0d exp=%0d", g_slv[0].frames, base + 2); end
    total++; if (g_slv[0].prev_frame !== 16'h9300) begin bad++; $display("FAIL ram_cmd_frame got=%h exp=9300", g_slv[0].prev_frame); end
    total++; if (g_slv[0].last_frame !== 16'hFF00) begin bad++; $display("FAIL ram_dummy_frame got=%h exp=ff00", g_slv[0].last_frame); end
    total++; if (r_rdata !== 8'hA5)   begin bad++; $display("FAIL ram_rdata_at_done got=%h exp=a5", r_rdata); end
    total++; if (rdata_v[0] !== 8'hA5) begin bad++; $display("FAIL ram_rdata_hold got=%h exp=a5", rdata_v[0]); end
    total++; if (g_slv[0].ram[3] !== 8'hA5) begin bad++; $display("FAIL ram_slave_mem got=%h exp=a5", g_slv[0].ram[3]); end
  endtask

  task automatic test_input_read;
    gpioin = 10'h3C6;
    txn0(1'b1, 7'h0E, 8'h00, 1'b0);
    total++; if (r_rdata !== 8'hC6) begin bad++; $display("FAIL in_lo_rdata got=%h exp=c6", r_rdata); end
    txn0(1'b1, 7'h0F, 8'h00, 1'b0);
    total++; if (r_rdata !== 8'h03) begin bad++; $display("FAIL in_hi_rdata got=%h exp=03", r_rdata); end
    // A write must leave the previous read result in place.
    txn0(1'b0, 7'h05, 8'h00, 1'b0);
    total++; if (r_done_at != 137)    begin bad++; $display("FAIL wr_keep_latency got=%0d exp=137", r_done_at); end
    total++; if (rdata_v[0] !== 8'h03) begin bad++; $display("FAIL wr_keep_rdata got=%h exp=03", rdata_v[0]); end
  endtask

  task automatic test_busy_reject;
    int base;
    base = g_slv[0].frames;
    txn0(1'b0, 7'h04, 8'h01, 1'b1);
    total++; if (r_dones != 1)      begin bad++; $display("FAIL rej_dones got=%0d exp=1", r_dones); end
    total++; if (r_cs_falls != 1)   begin bad++; $display("FAIL rej_cs_falls got=%0d exp=1", r_cs_falls); end
    total++; if (r_done_at != 137)  begin bad++; $display("FAIL rej_latency got=%0d exp=137", r_done_at); end
    total++; if (g_slv[0].frames != base + 1) begin bad++; $display("FAIL rej_frames got=%0d exp=%0d", g_slv[0].frames, base + 1); end
    total++; if (g_slv[0].last_frame !== 16'h0401) begin bad++; $display("FAIL rej_frame got=%h exp=0401", g_slv[0].last_frame); end
    total++; if (g_slv[0].gpioout[5] !== 1'b0) begin bad++; $display("FAIL rej_gpioout5 got=%b exp=0", g_slv[0].gpioout[5]); end
  endtask

  task automatic test_reset_mid;
    int   rises;
    logic p;
    bit   hit;
    rises = 0; p = sclk_v[0]; hit = 0;
    start_v[0] = 1'b1; rw_v[0] = 1'b0; addr_v[0] = 7'h06; wdata_v[0] = 8'h01;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (sclk_v[0] && !p) rises++;
      p = sclk_v[0];
      if (rises == 7) begin
        hit = 1;
        break;
      end
    end
    total++; if (!hit) begin bad++; $display("FAIL abort_reach_edge7 got rises=%0d exp=7", rises); end
    rstn_v[0] = 1'b0;
    #1;
    total++; if (cs_v[0] !== 1'b1)     begin bad++; $display("FAIL abort_cs got=%b exp=1", cs_v[0]); end
    total++; if (sclk_v[0] !== 1'b0)   begin bad++; $display("FAIL abort_sclk got=%b exp=0", sclk_v[0]); end
    total++; if (busy_v[0] !== 1'b0)   begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_v[0]); end
    total++; if (rdata_v[0] !== 8'h00) begin bad++; $display("FAIL abort_rdata got=%h exp=00", rdata_v[0]); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (done_v[0] !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", done_v[0]); end
    end
    rstn_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (done_v[0] !== 1'b0 || cs_v[0] !== 1'b1) begin bad++; $display("FAIL abort_release got done=%b cs=%b exp done=0 cs=1", done_v[0], cs_v[0]); end
    txn0(1'b0, 7'h0A, 8'h01, 1'b0);
    total++; if (r_done_at != 137) begin bad++; $display("FAIL abort_next_latency got=%0d exp=137", r_done_at); end
    total++; if (g_slv[0].gpioout !== 10'h3FF) begin bad++; $display("FAIL abort_next_gpioout got=%h exp=3ff", g_slv[0].gpioout); end
  endtask

  // Instance 1 (divider 1, gap 1): each start is issued the cycle after the previous done.
  // Every rising edge must present the expected frame bit, unchanged from the cycle before.
  // cs-high runs are 1 cycle between the two frames of a read and 3 cycles between
  // transactions (gap, done cycle, start cycle).
  task automatic test_back_to_back;
    logic [15:0] exp_q[$];
    int          gap_q[$];
    logic        t_rw  [4];
    logic [6:0]  t_addr[4];
    logic [7:0]  t_wd  [4];
    logic [7:0]  t_rd  [4];
    int          t_lat [4];
    logic [15:0] cur;
    logic        eb;
    int          idx, t0, cyc, rk, run, exp_gap;
    logic        p_sclk, p_mosi, p_cs, seen_low, pend;

    gpioin = 10'h3C6;
    t_rw   = '{1'b0, 1'b1, 1'b0, 1'b1};
    t_addr = '{7'h12, 7'h12, 7'h01, 7'h0E};
    t_wd   = '{8'h5A, 8'h00, 8'h01, 8'h00};
    t_rd   = '{8'h00, 8'h5A, 8'h00, 8'hC6};
    t_lat  = '{35, 69, 35, 69};
    exp_q  = '{16'h125A, 16'h9200, 16'hFF00, 16'h0101, 16'h8E00, 16'hFF00};
    gap_q  = '{3, 1, 3, 3, 1};

    idx = 0; t0 = 0; cyc = 0; rk = 0; run = 0;
    p_sclk = sclk_v[1]; p_mosi = mosi_v[1]; p_cs = cs_v[1]; seen_low = 0; pend = 0;
    start_v[1] = 1'b1; rw_v[1] = t_rw[0]; addr_v[1] = t_addr[0]; wdata_v[1] = t_wd[0];

    while (idx < 4 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start_v[1] = 1'b0;

      if (!cs_v[1] && sclk_v[1] && !p_sclk) begin
        rk++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL b2b_extra_edge got rise=%0d exp=no frame", rk);
        end else begin
          cur = exp_q[0];
          eb  = cur[16 - rk];
          total++; if (mosi_v[1] !== eb)     begin bad++; $display("FAIL b2b_mosi_bit frame=%h edge=%0d got=%b exp=%b", cur, rk, mosi_v[1], eb); end
          total++; if (mosi_v[1] !== p_mosi) begin bad++; $display("FAIL b2b_mosi_stable frame=%h edge=%0d got=%b exp=%b", cur, rk, mosi_v[1], p_mosi); end
          if (rk == 16) void'(exp_q.pop_front());
        end
        if (rk == 16) rk = 0;
      end

      if (cs_v[1]) begin
        run++;
      end else if (p_cs) begin
        if (seen_low) begin
          total++;
          if (gap_q.size() == 0) begin
            bad++; $display("FAIL b2b_cs_gap got=%0d exp=no more frames", run);
          end else begin
            exp_gap = gap_q.pop_front();
            if (run != exp_gap) begin bad++; $display("FAIL b2b_cs_gap got=%0d exp=%0d", run, exp_gap); end
          end
        end
        seen_low = 1; run = 0; rk = 0;
      end

      if (done_v[1]) begin
        total++; if (cyc - t0 != t_lat[idx]) begin bad++; $display("FAIL b2b_latency txn=%0d got=%0d exp=%0d", idx, cyc - t0, t_lat[idx]); end
        if (t_rw[idx]) begin
          total++; if (rdata_v[1] !== t_rd[idx]) begin bad++; $display("FAIL b2b_rdata txn=%0d got=%h exp=%h", idx, rdata_v[1], t_rd[idx]); end
        end
        idx++;
        pend = (idx < 4);
      end else if (pend) begin
        start_v[1] = 1'b1; rw_v[1] = t_rw[idx]; addr_v[1] = t_addr[idx]; wdata_v[1] = t_wd[idx];
        t0 = cyc; pend = 0;
      end

      p_sclk = sclk_v[1]; p_mosi = mosi_v[1]; p_cs = cs_v[1];
    end
    start_v[1] = 1'b0;
    total++; if (idx != 4)          begin bad++; $display("FAIL b2b_timeout got=%0d done exp=4", idx); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_frames_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write_p3();
    test_ram_roundtrip();
    test_input_read();
    test_busy_reject();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
